// File: rtl/gs_pkg.sv
// GoldenSnitch shared types and constants.
// Imported by the fetch unit and its instruction buffer.
package gs_pkg;

    localparam int GS_XLEN = 32;
    localparam logic [31:0] GS_INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        IF_RUN,
        IF_TRAP
    } gs_ifetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } gs_fetch_entry_t;

    function automatic logic [31:0] gs_word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/gs_ifetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, word} entries.
// Registered storage, no bypass; flush empties it in one cycle.
module gs_ifetch_fifo
    import gs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  gs_fetch_entry_t       data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output gs_fetch_entry_t       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);

    gs_fetch_entry_t mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [AW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // The credit scheme upstream must never overfill the buffer.
    assert property (@(posedge clk) disable iff (!rst)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/gs_ifetch.sv
// GoldenSnitch instruction fetch: PC, request credit, response drop.
// Define GS_IFETCH_MISALIGN_EN to trap on misaligned redirect targets.
module gs_ifetch
    import gs_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef GS_IFETCH_MISALIGN_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [GS_XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [GS_XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]      outs_q, outs_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic               alive_q;
    gs_ifetch_state_e   state_q, state_d;

    logic [CW-1:0]      fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    gs_fetch_entry_t    push_ent;
    gs_fetch_entry_t    head;
    logic [CW:0]        busy;
    logic               credit;
    logic               accept;
    logic               push;
    logic               pop;

    assign busy   = {1'b0, outs_q} + {1'b0, fifo_cnt};
    assign credit = busy < (CW+1)'(FIFO_DEPTH);

    assign imem_req_valid = alive_q && (state_q == IF_RUN)
                          && !redirect_valid && credit;
    assign imem_req_addr  = fetch_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // Stale words are counted off by drop_q; a redirect kills this cycle's word.
    assign push = imem_rsp_valid && (drop_q == '0)
                && !redirect_valid && (state_q == IF_RUN);
    assign pop  = instr_valid && instr_ready;

    assign push_ent = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outs_d     = outs_q;
        drop_d     = drop_q;
        state_d    = state_q;
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            outs_d     = outs_d + 1'b1;
        end
        if (imem_rsp_valid) begin
            outs_d = outs_d - 1'b1;
            if (drop_q != '0) begin
                drop_d = drop_q - 1'b1;
            end
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (redirect_valid) begin
            fetch_pc_d = gs_word_align(redirect_pc);
            rsp_pc_d   = gs_word_align(redirect_pc);
            drop_d     = outs_d;
`ifdef GS_IFETCH_MISALIGN_EN
            state_d = (redirect_pc[1:0] != 2'b00) ? IF_TRAP : IF_RUN;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outs_q     <= '0;
            drop_q     <= '0;
            alive_q    <= 1'b0;
            state_q    <= IF_RUN;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outs_q     <= outs_d;
            drop_q     <= drop_d;
            alive_q    <= 1'b1;
            state_q    <= state_d;
        end
    end

    gs_ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_ent),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_o  (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

`ifdef GS_IFETCH_MISALIGN_EN
    assign fetch_misalign = (state_q == IF_TRAP);
    logic unused_full;
    assign unused_full = fifo_full;
`else
    logic unused_bits;
    assign unused_bits = ^redirect_pc[1:0] ^ fifo_full;
`endif

endmodule

// File: tb/tb_gs_ifetch.sv
// Self-checking bench for gs_ifetch: directed table, corner
// sequences and randomized traffic against a transaction model.
module tb_gs_ifetch;
    import gs_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          D   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign;

    always #5 clk = ~clk;

    gs_ifetch #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef GS_IFETCH_MISALIGN_EN
        ,
        .fetch_misalign (misalign)
`endif
    );

`ifndef GS_IFETCH_MISALIGN_EN
    assign misalign = 1'b0;
`endif

    int ntests = 0;
    int nfail  = 0;

    // memory environment
    typedef struct {
        int          due;
        logic [31:0] data;
    } mrsp_t;
    mrsp_t mq[$];
    int    lat = 1;
    int    last_due = -100;
    int    cyc = 0;

    // reference model: requests in flight and buffered words
    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } fl_t;
    fl_t             m_fl[$];
    gs_fetch_entry_t m_fifo[$];
    logic [31:0]     m_pc;
    bit              m_alive;
    bit              m_trap;

    // driven inputs for the next cycle
    bit          drv_ready, drv_iready, drv_redir;
    logic [31:0] drv_rpc;

    // DUT outputs observed before the last edge
    bit          obs_rv, obs_acc, obs_iv, obs_mis;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fl.delete();
        m_fifo.delete();
        mq.delete();
        m_pc     = RPC;
        m_alive  = 0;
        m_trap   = 0;
        cyc      = 0;
        last_due = -100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic cycle();
        bit          exp_rv, exp_iv, rv, rdy;
        logic [31:0] rdata;
        fl_t         f;
        int          due;
        @(negedge clk);
        imem_req_ready = drv_ready;
        instr_ready    = drv_iready;
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        exp_rv = m_alive && !m_trap && !drv_redir
               && (m_fl.size() + m_fifo.size() < D);
        exp_iv = (m_fifo.size() > 0);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (exp_iv && instr_valid) begin
            chk("instr_pc", instr_pc, m_fifo[0].pc);
            chk("instr", instr, m_fifo[0].instr);
            chk("instr_vs_mem", instr, memword(instr_pc));
        end
        chk("misalign", 32'(misalign), 32'(m_trap));
        obs_rv    = imem_req_valid;
        obs_acc   = imem_req_valid && imem_req_ready;
        obs_addr  = imem_req_addr;
        obs_iv    = instr_valid;
        obs_pc    = instr_pc;
        obs_instr = instr;
        obs_mis   = misalign;
        rv    = imem_rsp_valid;
        rdata = imem_rsp_data;
        rdy   = drv_ready;
        @(posedge clk);
        if (rv) void'(mq.pop_front());
        if (obs_acc) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{due: due, data: memword(obs_addr)});
            last_due = due;
        end
        if (exp_rv && rdy) begin
            m_fl.push_back('{pc: m_pc, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (exp_iv && drv_iready) void'(m_fifo.pop_front());
        if (rv && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!f.stale && !drv_redir && !m_trap)
                m_fifo.push_back('{pc: f.pc, instr: rdata});
        end
        if (drv_redir) begin
            m_fifo.delete();
            foreach (m_fl[k]) m_fl[k].stale = 1'b1;
            m_pc = {drv_rpc[31:2], 2'b00};
`ifdef GS_IFETCH_MISALIGN_EN
            m_trap = (drv_rpc[1:0] != 2'b00);
`endif
        end
        m_alive = 1;
        cyc++;
    endtask

    task automatic idle_inputs();
        drv_ready  = 1;
        drv_iready = 1;
        drv_redir  = 0;
        drv_rpc    = '0;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        drv_redir = 1;
        drv_rpc   = t;
        cycle();
        drv_redir = 0;
    endtask

    task automatic wait_pop(input string nm, output logic [31:0] pc);
        int n = 0;
        bit ok;
        do begin
            cycle();
            n++;
            ok = obs_iv && drv_iready;
        end while (!ok && n < 40);
        chk(nm, 32'(ok), 32'd1);
        pc = obs_pc;
    endtask

    task automatic wait_acc(input string nm, output logic [31:0] a);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!obs_acc && n < 40);
        chk(nm, 32'(obs_acc), 32'd1);
        a = obs_addr;
    endtask

    typedef struct {
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] p, q, r;
        int          accs;

        // straight-line, 1-cycle memory, credit-limited fill
        tbl[0] = '{0, 32'h100, 0, 32'h0};
        tbl[1] = '{1, 32'h100, 0, 32'h0};
        tbl[2] = '{1, 32'h104, 0, 32'h0};
        tbl[3] = '{0, 32'h108, 1, 32'h100};
        tbl[4] = '{1, 32'h108, 1, 32'h104};
        tbl[5] = '{1, 32'h10C, 0, 32'h0};
        tbl[6] = '{0, 32'h110, 1, 32'h108};
        tbl[7] = '{1, 32'h110, 1, 32'h10C};

        idle_inputs();
        lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("tbl%0d_rv", i), 32'(obs_rv), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d_addr", i), obs_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_iv", i), 32'(obs_iv), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv)
                chk($sformatf("tbl%0d_pc", i), obs_pc, tbl[i].e_pc);
        end

        // decode stall: credit bounds requests, order kept after release
        drv_iready = 0;
        accs = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (obs_acc) accs++;
        end
        chk("stall_accepts_le_depth", 32'(accs <= D), 32'd1);
        drv_iready = 1;
        wait_pop("stall_pop0", p);
        for (int i = 1; i < 4; i++) begin
            wait_pop($sformatf("stall_pop%0d", i), q);
            chk($sformatf("stall_order%0d", i), q, p + 32'd4);
            p = q;
        end

        // redirect with two requests in flight, 3-cycle memory
        lat = 3;
        for (int i = 0; i < 20 && m_fl.size() < 2; i++) cycle();
        chk("two_in_flight", 32'(m_fl.size()), 32'd2);
        redirect_to(32'h200);
        wait_pop("redir_pop", p);
        chk("redir_first_pc", p, 32'h200);
        chk("redir_first_word", obs_instr, memword(32'h200));

        // redirect on the same cycle a response arrives
        lat = 2;
        for (int i = 0; i < 20; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc) break;
            cycle();
        end
        redirect_to(32'h280);
        wait_pop("coinc_pop", p);
        chk("coinc_first_pc", p, 32'h280);

        // address wrap
        lat = 1;
        redirect_to(32'hFFFF_FFFC);
        wait_acc("wrap_acc0", q);
        chk("wrap_addr0", q, 32'hFFFF_FFFC);
        wait_acc("wrap_acc1", q);
        chk("wrap_addr1", q, 32'h0000_0000);
        wait_pop("wrap_pop0", p);
        chk("wrap_pc0", p, 32'hFFFF_FFFC);
        wait_pop("wrap_pop1", p);
        chk("wrap_pc1", p, 32'h0000_0000);

`ifdef GS_IFETCH_MISALIGN_EN
        redirect_to(32'h302);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("trap_no_req", 32'(obs_rv), 32'd0);
            chk("trap_flag", 32'(obs_mis), 32'd1);
            chk("trap_empty", 32'(obs_iv), 32'd0);
        end
        redirect_to(32'h400);
        wait_acc("trap_exit_acc", q);
        chk("trap_exit_addr", q, 32'h400);
        chk("trap_exit_flag", 32'(obs_mis), 32'd0);
`else
        redirect_to(32'h302);
        wait_acc("lsb_acc", q);
        chk("lsb_cleared", q, 32'h300);
`endif

        // randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            drv_ready  = ($urandom_range(0, 3) != 0);
            drv_iready = ($urandom_range(0, 9) < 7);
            drv_redir  = ($urandom_range(0, 29) == 0);
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
            drv_rpc = r;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
